sphere_point_monitor: RTL and testbench

//  Consumer end of the sphere_32bit point stream. Drives pop_enable, accepts N points
//  (sphere_x/y/z, valid), and computes r^2 = x^2+y^2+z^2 through a pipeline.

---
 rtl/sphere_mon_pkg.sv | 22 ++
 rtl/sphere_r2_pipe.sv | 99 +++++++++
 rtl/sphere_point_monitor.sv | 191 +++++++++++++++++++
 tb/tb_sphere_point_monitor.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sphere_mon_pkg.sv
// Shared types and constants for the sphere point monitor.
// Optional z-band counters are enabled with SPHERE_MON_ZBAND_EN.
package sphere_mon_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef enum logic [1:0] {ZB_NEAR, ZB_POS, ZB_NEG} zband_t;
    typedef logic [2:0] octant_t;

    localparam int PT_W  = 32;
    localparam int SQ_W  = 64;
    localparam int SUM_W = 66;

    localparam logic [31:0] ONE_Q30 = 32'h4000_0000;

    function automatic logic [31:0] abs_diff(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return (a >= b) ? a - b : b - a;
    endfunction

endpackage

// File: rtl/sphere_r2_pipe.sv
// Two-stage r^2 pipeline: squares, then sum with tolerance compare.
// Carries valid, octant and (with SPHERE_MON_ZBAND_EN) z-band sideband.
module sphere_r2_pipe
    import sphere_mon_pkg::*;
#(
    parameter logic [31:0] TOL_Q30 = 32'd214748365
`ifdef SPHERE_MON_ZBAND_EN
    ,
    parameter logic [31:0] ZBAND = 32'd214748365
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic signed [PT_W-1:0] x,
    input  logic signed [PT_W-1:0] y,
    input  logic signed [PT_W-1:0] z,
    output logic                   out_valid,
    output logic                   pipe_busy,
    output logic [31:0]            r2,
    output logic                   err,
    output octant_t                oct
`ifdef SPHERE_MON_ZBAND_EN
    ,
    output zband_t                 zband
`endif
);

    logic                   s1_valid;
    logic signed [SQ_W-1:0] sq_x;
    logic signed [SQ_W-1:0] sq_y;
    logic signed [SQ_W-1:0] sq_z;
    octant_t                s1_oct;

    logic                   s2_valid;
    logic [SUM_W-1:0]       sum;
    octant_t                s2_oct;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            sq_x     <= '0;
            sq_y     <= '0;
            sq_z     <= '0;
            s1_oct   <= '0;
            s2_valid <= 1'b0;
            sum      <= '0;
            s2_oct   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                sq_x   <= SQ_W'(x) * SQ_W'(x);
                sq_y   <= SQ_W'(y) * SQ_W'(y);
                sq_z   <= SQ_W'(z) * SQ_W'(z);
                s1_oct <= {z[PT_W-1], y[PT_W-1], x[PT_W-1]};
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                // squares are non-negative, so zero-extension is exact
                sum    <= {2'b00, sq_x} + {2'b00, sq_y} + {2'b00, sq_z};
                s2_oct <= s1_oct;
            end
        end
    end

`ifdef SPHERE_MON_ZBAND_EN
    localparam logic signed [31:0] ZB = ZBAND;

    zband_t s1_zb;
    zband_t s2_zb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_zb <= ZB_NEAR;
            s2_zb <= ZB_NEAR;
        end else begin
            if (in_valid) begin
                if (z > ZB)       s1_zb <= ZB_POS;
                else if (z < -ZB) s1_zb <= ZB_NEG;
                else              s1_zb <= ZB_NEAR;
            end
            if (s1_valid) s2_zb <= s1_zb;
        end
    end

    assign zband = s2_zb;
`endif

    // only the Q2.30 window of the sum is reported
    logic unused_bits;
    assign unused_bits = ^{sum[SUM_W-1:64], sum[31:0]};

    assign r2        = sum[63:32];
    assign err       = abs_diff(r2, ONE_Q30) > TOL_Q30;
    assign oct       = s2_oct;
    assign out_valid = s2_valid;
    assign pipe_busy = s1_valid | s2_valid;

endmodule

// File: rtl/sphere_point_monitor.sv
// Sphere point stream consumer: r^2 check, octant/error counters, readout.
// Define SPHERE_MON_ZBAND_EN to enable the zpos/zneg/znear band counters.
module sphere_point_monitor
    import sphere_mon_pkg::*;
#(
    parameter int          COUNT_W = 16,
    parameter logic [31:0] TOL_Q30 = 32'd214748365
`ifdef SPHERE_MON_ZBAND_EN
    ,
    parameter logic [31:0] ZBAND   = 32'd214748365
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_points,
    input  logic [31:0]        sphere_x,
    input  logic [31:0]        sphere_y,
    input  logic [31:0]        sphere_z,
    input  logic               valid,
    output logic               pop_enable,
    output logic               busy,
    output logic               done,
    input  logic [2:0]         rd_idx,
    output logic [COUNT_W-1:0] rd_count,
    output logic [COUNT_W-1:0] err_count,
    output logic [31:0]        last_r2,
    output logic [COUNT_W-1:0] zpos,
    output logic [COUNT_W-1:0] zneg,
    output logic [COUNT_W-1:0] znear
);

    function automatic logic [COUNT_W-1:0] sat_inc(
        input logic [COUNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t             state;
    logic [COUNT_W-1:0] target;
    logic [COUNT_W-1:0] accepted;
    logic               accept;
    logic               start_ok;

    logic               in_v;
    logic signed [31:0] in_x;
    logic signed [31:0] in_y;
    logic signed [31:0] in_z;

    logic               p_valid;
    logic               p_busy;
    logic [31:0]        p_r2;
    logic               p_err;
    octant_t            p_oct;

    logic [COUNT_W-1:0] oct_cnt [8];

    assign accept   = valid && (state == RUN) && (accepted < target);
    assign start_ok = start && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            target     <= '0;
            accepted   <= '0;
            pop_enable <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        target   <= num_points;
                        accepted <= '0;
                        if (num_points != '0) begin
                            state      <= RUN;
                            pop_enable <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        accepted   <= accepted + 1'b1;
                        pop_enable <= COUNT_W'(accepted + 1'b1) < target;
                    end
                    if (accepted == target) state <= DRAIN;
                end
                DRAIN: begin
                    if (!in_v && !p_busy && !p_valid) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // input register: the accepted point enters the pipe one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_v <= 1'b0;
            in_x <= '0;
            in_y <= '0;
            in_z <= '0;
        end else begin
            in_v <= accept;
            if (accept) begin
                in_x <= sphere_x;
                in_y <= sphere_y;
                in_z <= sphere_z;
            end
        end
    end

`ifdef SPHERE_MON_ZBAND_EN
    zband_t p_zb;
`endif

    sphere_r2_pipe #(
        .TOL_Q30   (TOL_Q30)
`ifdef SPHERE_MON_ZBAND_EN
        ,
        .ZBAND     (ZBAND)
`endif
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_v),
        .x         (in_x),
        .y         (in_y),
        .z         (in_z),
        .out_valid (p_valid),
        .pipe_busy (p_busy),
        .r2        (p_r2),
        .err       (p_err),
        .oct       (p_oct)
`ifdef SPHERE_MON_ZBAND_EN
        ,
        .zband     (p_zb)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) oct_cnt[i] <= '0;
            err_count <= '0;
            last_r2   <= '0;
        end else if (start_ok) begin
            for (int i = 0; i < 8; i++) oct_cnt[i] <= '0;
            err_count <= '0;
            last_r2   <= '0;
        end else if (p_valid) begin
            last_r2        <= p_r2;
            oct_cnt[p_oct] <= sat_inc(oct_cnt[p_oct]);
            if (p_err) err_count <= sat_inc(err_count);
        end
    end

`ifdef SPHERE_MON_ZBAND_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zpos  <= '0;
            zneg  <= '0;
            znear <= '0;
        end else if (start_ok) begin
            zpos  <= '0;
            zneg  <= '0;
            znear <= '0;
        end else if (p_valid) begin
            unique case (p_zb)
                ZB_POS:  zpos  <= sat_inc(zpos);
                ZB_NEG:  zneg  <= sat_inc(zneg);
                default: znear <= sat_inc(znear);
            endcase
        end
    end
`else
    assign zpos  = '0;
    assign zneg  = '0;
    assign znear = '0;
`endif

    assign busy     = (state != IDLE);
    assign rd_count = oct_cnt[rd_idx];

endmodule

// File: tb/tb_sphere_point_monitor.sv
// Bench for sphere_point_monitor: directed table, reset-abort, random runs.
// Honours SPHERE_MON_ZBAND_EN for the z-band expectations.
module tb_sphere_point_monitor;

    localparam logic [31:0] TOL = 32'd214748365;
    localparam logic [31:0] ONE = 32'h4000_0000;
    localparam longint      ZBL = 64'd214748365;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] num_points = '0;
    logic [31:0] sphere_x = '0;
    logic [31:0] sphere_y = '0;
    logic [31:0] sphere_z = '0;
    logic [2:0]  rd_idx = '0;
    logic        pop_enable;
    logic        busy;
    logic        done;
    logic [15:0] rd_count;
    logic [15:0] err_count;
    logic [31:0] last_r2;
    logic [15:0] zpos;
    logic [15:0] zneg;
    logic [15:0] znear;

    int checks = 0;
    int failures = 0;

    logic [31:0] pts_x[$];
    logic [31:0] pts_y[$];
    logic [31:0] pts_z[$];

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        int          oct;
        int          err;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t tbl[11];

    always #5 clk = ~clk;

    sphere_point_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_points (num_points),
        .sphere_x   (sphere_x),
        .sphere_y   (sphere_y),
        .sphere_z   (sphere_z),
        .valid      (valid),
        .pop_enable (pop_enable),
        .busy       (busy),
        .done       (done),
        .rd_idx     (rd_idx),
        .rd_count   (rd_count),
        .err_count  (err_count),
        .last_r2    (last_r2),
        .zpos       (zpos),
        .zneg       (zneg),
        .znear      (znear)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input logic [31:0] act,
                           input logic [31:0] lo, input logic [31:0] hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h..%0h", name, act, lo, hi);
        end
    endtask

    // r^2 = (x^2+y^2+z^2) scaled to Q2.30, truncated, modulo 2^32
    function automatic logic [31:0] model_r2(input logic [31:0] x,
                                             input logic [31:0] y,
                                             input logic [31:0] z);
        longint a = longint'($signed(x));
        longint b = longint'($signed(y));
        longint c = longint'($signed(z));
        logic [65:0] s;
        s = 66'(a * a) + 66'(b * b) + 66'(c * c);
        return s[63:32];
    endfunction

    function automatic int model_err(input logic [31:0] r2);
        longint d = longint'(r2) - longint'(ONE);
        if (d < 0) d = -d;
        return (d > longint'(TOL)) ? 1 : 0;
    endfunction

    function automatic longint isqrt(input longint t);
        longint r = longint'($sqrt(real'(t)));
        while (r * r > t) r--;
        while ((r + 1) * (r + 1) <= t) r++;
        return r;
    endfunction

    // point in octant 0 whose truncated r^2 equals k exactly
    task automatic make_pt(input logic [31:0] k, output vec_t v);
        longint t = longint'(k) <<< 32;
        longint x = isqrt(t / 2);
        longint r = t - x * x;
        longint y = isqrt(r);
        longint r2 = r - y * y;
        longint z = isqrt(r2);
        if (z * z < r2) z++;
        v.x = 32'(x);
        v.y = 32'(y);
        v.z = 32'(z);
        v.oct = 0;
        v.lo = k;
        v.hi = k;
        v.err = 0;
    endtask

    function automatic logic [31:0] to_q31(input real v);
        real s = v * 2147483648.0;
        if (s > 2147483647.0) s = 2147483647.0;
        if (s < -2147483648.0) s = -2147483648.0;
        return 32'($rtoi(s));
    endfunction

    task automatic sphere_pt(output logic [31:0] x, output logic [31:0] y,
                             output logic [31:0] z);
        real a, b, c, n;
        do begin
            a = $urandom_range(2000) / 1000.0 - 1.0;
            b = $urandom_range(2000) / 1000.0 - 1.0;
            c = $urandom_range(2000) / 1000.0 - 1.0;
            n = a * a + b * b + c * c;
        end while (n < 0.01);
        n = $sqrt(n);
        x = to_q31(a / n);
        y = to_q31(b / n);
        z = to_q31(c / n);
    endtask

    task automatic push_pt(input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z);
        pts_x.push_back(x);
        pts_y.push_back(y);
        pts_z.push_back(z);
    endtask

    task automatic clear_pts();
        pts_x.delete();
        pts_y.delete();
        pts_z.delete();
    endtask

    task automatic fill_pts(input int n, input int sphere_pct);
        logic [31:0] x, y, z;
        clear_pts();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(99) < sphere_pct) sphere_pt(x, y, z);
            else begin
                x = $urandom;
                y = $urandom;
                z = $urandom;
            end
            push_pt(x, y, z);
        end
    endtask

    // Presents pts in order with valid at vpct%, then junk after the count.
    task automatic run_pts(input int n, input int vpct);
        int acc = 0;
        int cyc = 0;
        int nd = 0;
        @(negedge clk);
        start = 1'b1;
        num_points = 16'(n);
        @(negedge clk);
        start = 1'b0;
        num_points = 16'($urandom);
        while (acc < n && cyc < 4000) begin
            chk("pop_run", 64'(pop_enable), 64'd1);
            if ($urandom_range(99) < vpct) begin
                valid = 1'b1;
                sphere_x = pts_x[acc];
                sphere_y = pts_y[acc];
                sphere_z = pts_z[acc];
            end else begin
                valid = 1'b0;
                sphere_x = $urandom;
                sphere_y = $urandom;
                sphere_z = $urandom;
            end
            @(negedge clk);
            if (valid) acc++;
            cyc++;
        end
        chk("pop_fall", 64'(pop_enable), 64'd0);
        cyc = 0;
        while (busy && cyc < 64) begin
            if (done) nd++;
            valid = (cyc < 3);
            sphere_x = $urandom;
            sphere_y = $urandom;
            sphere_z = $urandom;
            @(negedge clk);
            cyc++;
        end
        valid = 1'b0;
        chk("drain_timeout", 64'(busy), 64'd0);
        chk("done_pulses", 64'(nd), 64'd1);
    endtask

    task automatic check_results(input int n);
        int eo[8];
        int ee = 0;
        int zp = 0;
        int zn = 0;
        int zr = 0;
        logic [31:0] elr = '0;
        logic [31:0] r;
        logic [2:0] o;
        for (int k = 0; k < 8; k++) eo[k] = 0;
        for (int i = 0; i < n; i++) begin
            r = model_r2(pts_x[i], pts_y[i], pts_z[i]);
            o = {pts_z[i][31], pts_y[i][31], pts_x[i][31]};
            eo[o]++;
            ee += model_err(r);
            elr = r;
            if (longint'($signed(pts_z[i])) > ZBL) zp++;
            else if (longint'($signed(pts_z[i])) < -ZBL) zn++;
            else zr++;
        end
        chk("err_count", 64'(err_count), 64'(ee));
        chk("last_r2", 64'(last_r2), 64'(elr));
        for (int k = 0; k < 8; k++) begin
            rd_idx = 3'(k);
            #1;
            chk($sformatf("oct_cnt[%0d]", k), 64'(rd_count), 64'(eo[k]));
        end
`ifdef SPHERE_MON_ZBAND_EN
        chk("zpos", 64'(zpos), 64'(zp));
        chk("zneg", 64'(zneg), 64'(zn));
        chk("znear", 64'(znear), 64'(zr));
`else
        chk("zpos", 64'(zpos), 64'(zp * 0));
        chk("zneg", 64'(zneg), 64'(zn * 0));
        chk("znear", 64'(znear), 64'(zr * 0));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pop"}, 64'(pop_enable), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err_count), 64'd0);
        chk({tag, "_r2"}, 64'(last_r2), 64'd0);
        chk({tag, "_zb"}, 64'({zpos, zneg, znear}), 64'd0);
        for (int k = 0; k < 8; k++) begin
            rd_idx = 3'(k);
            #1;
            chk({tag, "_oct"}, 64'(rd_count), 64'd0);
        end
    endtask

    initial begin
        vec_t v;
        int acc;
        int nd;
        int osum;
        logic [31:0] x, y, z;

        tbl[0] = '{32'h4000_0000, 32'h4000_0000, 32'h5A82_7999, 0, 0,
                   32'h3FF0_0000, 32'h4010_0000};
        tbl[1] = '{32'h4000_0000, 32'h0, 32'h0, 0, 1,
                   32'h1000_0000, 32'h1000_0000};
        tbl[2] = '{32'hC000_0000, 32'hC000_0000, 32'hA57D_8667, 7, 0,
                   32'h3FF0_0000, 32'h4010_0000};
        tbl[3] = '{32'h0, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0};
        tbl[4] = '{32'h8000_0000, 32'h0, 32'h0, 1, 0,
                   32'h4000_0000, 32'h4000_0000};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 7, 1,
                   32'hC000_0000, 32'hC000_0000};
        tbl[6] = '{32'h0, 32'hC000_0000, 32'h0, 2, 1,
                   32'h1000_0000, 32'h1000_0000};
        make_pt(ONE + TOL, v);
        tbl[7] = v;
        make_pt(ONE + TOL + 1, v);
        v.err = 1;
        tbl[8] = v;
        make_pt(ONE - TOL, v);
        tbl[9] = v;
        make_pt(ONE - TOL - 1, v);
        v.err = 1;
        tbl[10] = v;

        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            clear_pts();
            push_pt(tbl[i].x, tbl[i].y, tbl[i].z);
            run_pts(1, 100);
            chk($sformatf("vec%0d_err", i), 64'(err_count), 64'(tbl[i].err));
            chk_rng($sformatf("vec%0d_r2", i), last_r2, tbl[i].lo, tbl[i].hi);
            rd_idx = 3'(tbl[i].oct);
            #1;
            chk($sformatf("vec%0d_oct", i), 64'(rd_count), 64'd1);
`ifdef SPHERE_MON_ZBAND_EN
            if (i == 2) chk("vec2_zneg", 64'(zneg), 64'd1);
`endif
        end

        // valid held high past the requested count
        fill_pts(3, 100);
        run_pts(3, 100);
        check_results(3);

        // zero-length run
        clear_pts();
        run_pts(0, 100);
        check_results(0);

        // reset mid-run aborts without a done pulse
        fill_pts(8, 100);
        @(negedge clk);
        start = 1'b1;
        num_points = 16'd8;
        @(negedge clk);
        start = 1'b0;
        acc = 0;
        while (acc < 4) begin
            valid = 1'b1;
            sphere_x = pts_x[acc];
            sphere_y = pts_y[acc];
            sphere_z = pts_z[acc];
            @(negedge clk);
            acc++;
        end
        valid = 1'b0;
        rst_n = 1'b0;
        #1 check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("abort_idle", 64'(nd), 64'd0);
        fill_pts(8, 100);
        run_pts(8, 70);
        check_results(8);
        chk("fresh_err", 64'(err_count), 64'd0);
        osum = 0;
        for (int k = 0; k < 8; k++) begin
            rd_idx = 3'(k);
            #1;
            osum += int'(rd_count);
        end
        chk("fresh_octsum", 64'(osum), 64'd8);

        // randomized runs against the reference model
        for (int r = 0; r < 12; r++) begin
            int n = $urandom_range(24, 1);
            fill_pts(n, 50);
            run_pts(n, $urandom_range(100, 20));
            check_results(n);
        end

        // an all-sphere random run must report no errors
        for (int i = 0; i < 1; i++) begin
            clear_pts();
            for (int j = 0; j < 16; j++) begin
                sphere_pt(x, y, z);
                push_pt(x, y, z);
            end
            run_pts(16, 60);
            chk("sphere_err", 64'(err_count), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
